led_sequencer: RTL and testbench



---
 rtl/led_seq_pkg.sv | 33 +++
 rtl/led_sequencer_step_divider.sv | 34 +++
 rtl/led_sequencer.sv | 121 ++++++++++++
 tb/tb_led_sequencer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared types for the LED pattern sequencer.
//   mode_t        : 2-bit mode code carried on the mode request port
//   MODE_*        : mode code constants (OFF, CHASE, BLINK, COUNT)
//   state_t       : pattern FSM state encoding
//   mode_to_state : maps a requested mode code onto its FSM state
package led_seq_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_OFF   = 2'd0;
    localparam mode_t MODE_CHASE = 2'd1;
    localparam mode_t MODE_BLINK = 2'd2;
    localparam mode_t MODE_COUNT = 2'd3;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_CHASE,
        ST_BLINK,
        ST_COUNT
    } state_t;

    function automatic state_t mode_to_state(input mode_t m);
        state_t s;
        case (m)
            MODE_CHASE: s = ST_CHASE;
            MODE_BLINK: s = ST_BLINK;
            MODE_COUNT: s = ST_COUNT;
            default:    s = ST_OFF;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/led_sequencer_step_divider.sv
// step_divider: pattern step timebase.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   en    : 1 = counter advances, 0 = counter and tick frozen
//   tick  : one-cycle pulse in the cycle after the counter sat at DELAY-1
module step_divider #(
    parameter int DELAY = 50000000,
    parameter int CNT_W = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    logic [CNT_W-1:0] cnt;
    logic             at_end;

    assign at_end = (cnt == CNT_W'(DELAY - 1));

    // With DELAY=1 at_end is permanently true, so every enabled cycle ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= en && at_end;
            if (en) begin
                cnt <= at_end ? '0 : cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// led_sequencer: sequenced pattern source for the board LED bank.
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   en         : 1 = pattern steps run, 0 = freeze step timing and LEDs
//   mode       : requested mode (OFF, CHASE, BLINK, COUNT)
//   mode_valid : mode request present
//   mode_ready : a mode request can be accepted
//   led        : registered LED drive
//   step_tick  : one-cycle pulse on each pattern step
//   brightness : 4-bit PWM duty, only when LED_SEQUENCER_PWM_EN is defined
// A mode request is held as pending and only takes effect on a later step
// tick, so pattern changes stay aligned to the step timebase.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int DELAY = 50000000,
    parameter int N_LED = 3,
    parameter int CNT_W = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             mode_valid,
    output logic             mode_ready,
`ifdef LED_SEQUENCER_PWM_EN
    input  logic [3:0]       brightness,
`endif
    output logic [N_LED-1:0] led,
    output logic             step_tick
);

    state_t           state, state_nxt;
    logic [N_LED-1:0] pat, pat_nxt;
    mode_t            pend_mode, pend_mode_nxt;
    logic             pend, pend_nxt;
    logic             tick;
    logic             accept;

    step_divider #(
        .DELAY (DELAY),
        .CNT_W (CNT_W)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .tick  (tick)
    );

    assign mode_ready = !pend;
    assign step_tick  = tick;
    assign accept     = mode_valid && !pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_OFF;
            pat       <= '0;
            pend      <= 1'b0;
            pend_mode <= MODE_OFF;
        end else begin
            state     <= state_nxt;
            pat       <= pat_nxt;
            pend      <= pend_nxt;
            pend_mode <= pend_mode_nxt;
        end
    end

    // Accept and apply never coincide: accept needs the pending flag clear,
    // apply needs it set. A request accepted on a tick therefore waits a step.
    always_comb begin
        state_nxt     = state;
        pat_nxt       = pat;
        pend_nxt      = pend;
        pend_mode_nxt = pend_mode;

        if (tick) begin
            if (pend) begin
                state_nxt = mode_to_state(pend_mode);
                pend_nxt  = 1'b0;
                case (state_nxt)
                    ST_CHASE: pat_nxt = N_LED'(1);
                    ST_BLINK: pat_nxt = '1;
                    default:  pat_nxt = '0;
                endcase
            end else begin
                case (state)
                    ST_CHASE: pat_nxt = {pat[N_LED-2:0], pat[N_LED-1]};
                    ST_BLINK: pat_nxt = ~pat;
                    ST_COUNT: pat_nxt = pat + N_LED'(1);
                    default:  pat_nxt = '0;
                endcase
            end
        end

        if (accept) begin
            pend_nxt      = 1'b1;
            pend_mode_nxt = mode;
        end
    end

`ifdef LED_SEQUENCER_PWM_EN
    logic [3:0]       pwm_cnt;
    logic [N_LED-1:0] led_q;

    // Brightness only masks the output; the pattern register keeps stepping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
            led_q   <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
            led_q   <= pat & {N_LED{pwm_cnt < brightness}};
        end
    end

    assign led = led_q;
`else
    assign led = pat;
`endif

endmodule

// File: tb/tb_led_sequencer.sv
module tb_led_sequencer;

    localparam int DELAY = 4;
    localparam int N_LED = 3;
    localparam int CNT_W = 4;
    localparam int LMASK = (1 << N_LED) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic [1:0]       mode = 2'd0;
    logic             mode_valid = 1'b0;
    logic             mode_ready;
    logic [N_LED-1:0] led;
    logic             step_tick;

    always #5 clk = ~clk;

    led_sequencer #(
        .DELAY (DELAY),
        .N_LED (N_LED),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .mode       (mode),
        .mode_valid (mode_valid),
        .mode_ready (mode_ready),
        .led        (led),
        .step_tick  (step_tick)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: enabled-cycle count decides ticks, patterns are plain
    // integers stepped by the mode rules.
    int m_en_cycles;
    bit m_tick;
    int m_pat;
    int m_cur;
    bit m_pend;
    int m_pmode;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int entry_val(input int md);
        case (md)
            1:       return 1;
            2:       return LMASK;
            default: return 0;
        endcase
    endfunction

    function automatic int advance(input int md, input int p);
        case (md)
            1:       return ((p * 2) % (1 << N_LED)) + (p >> (N_LED - 1));
            2:       return LMASK - p;
            3:       return (p + 1) % (1 << N_LED);
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_en_cycles = 0;
        m_tick      = 0;
        m_pat       = 0;
        m_cur       = 0;
        m_pend      = 0;
        m_pmode     = 0;
    endtask

    task automatic model_step();
        bit acc;
        if (!rst_n) begin
            model_reset();
            return;
        end
        acc = mode_valid && !m_pend;
        if (m_tick) begin
            if (m_pend) begin
                m_cur  = m_pmode;
                m_pat  = entry_val(m_cur);
                m_pend = 0;
            end else begin
                m_pat = advance(m_cur, m_pat);
            end
        end
        if (acc) begin
            m_pend  = 1;
            m_pmode = int'(mode);
        end
        if (en) begin
            m_en_cycles++;
            m_tick = (m_en_cycles % DELAY) == 0;
        end else begin
            m_tick = 0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_eq("led", 32'(led), 32'(m_pat));
        check_eq("step_tick", 32'(step_tick), 32'(m_tick));
        check_eq("mode_ready", 32'(mode_ready), 32'(!m_pend));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic request(input logic [1:0] md);
        mode       = md;
        mode_valid = 1'b1;
        cycle();
        mode_valid = 1'b0;
    endtask

    // Advance until the current cycle carries a tick, bounded.
    task automatic wait_tick_cycle();
        int k;
        k = 0;
        while (!m_tick && k < 3 * DELAY) begin
            cycle();
            k++;
        end
        check_eq("tick_reached", 32'(m_tick), 32'd1);
    endtask

    // Called at posedge+1; asserts reset well away from the clock edges.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("areset_led", 32'(led), 32'd0);
        check_eq("areset_ready", 32'(mode_ready), 32'd1);
        check_eq("areset_tick", 32'(step_tick), 32'd0);
        cycle();
        cycle();
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #12;
        check_eq("rst_led", 32'(led), 32'd0);
        check_eq("rst_ready", 32'(mode_ready), 32'd1);
        check_eq("rst_tick", 32'(step_tick), 32'd0);
        rst_n = 1'b1;

        en = 1'b1;
        run(12);

        request(2'd1);
        run(4 * DELAY + 2);
        check_eq("chase_mode", 32'(m_cur), 32'd1);

        request(2'd3);
        run(9 * DELAY + 2);

        wait_tick_cycle();
        request(2'd2);
        run(3 * DELAY);

        request(2'd1);
        en = 1'b0;
        run(20);
        en = 1'b1;
        run(2 * DELAY + 2);

        request(2'd2);
        check_eq("pending_before_reset", 32'(mode_ready), 32'd0);
        async_reset();
        run(2 * DELAY + 2);
        check_eq("pending_lost_led", 32'(led), 32'd0);

        for (int i = 0; i < 1500; i++) begin
            en         = ($urandom_range(0, 9) != 0);
            mode_valid = ($urandom_range(0, 4) == 0);
            mode       = 2'($urandom_range(0, 3));
            cycle();
            if ($urandom_range(0, 299) == 0) begin
                mode_valid = 1'b0;
                async_reset();
            end
        end
        mode_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
